// File: rtl/score_keeper_if.sv
`default_nettype none
// ============================================================================
// Module  : score_keeper_if
// Brief   : Control pulses and score/display outputs of score_keeper.
// Revision: 1.0 - initial release
// ============================================================================
interface score_keeper_if;
    logic        game_start;
    logic        hit;
    logic [31:0] score;
    logic [31:0] score_hi;
    logic [15:0] hi_bcd;
    logic        bcd_valid;
    logic        new_hi;
    logic        running;

    modport master (
        output game_start, hit,
        input  score, score_hi, hi_bcd, bcd_valid, new_hi, running
    );

    modport slave (
        input  game_start, hit,
        output score, score_hi, hi_bcd, bcd_valid, new_hi, running
    );
endinterface
`default_nettype wire

// File: rtl/score_keeper.sv
`default_nettype none
// ============================================================================
// Module  : score_keeper
// Brief   : Live score, delayed high-score commit and sequential BCD conversion.
// Revision: 1.0 - initial release
// ============================================================================
module score_keeper #(
    parameter int TICK_DIV  = 5_000_000,
    parameter int HI_DELAY  = 100_000_000,
    parameter int MAX_SCORE = 9999
) (
    input  wire            clk,
    input  wire            reset,
    score_keeper_if.slave  bus
);
    localparam int          C_TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int          C_DW         = (HI_DELAY > 1) ? $clog2(HI_DELAY) : 1;
    localparam logic [C_TW-1:0] C_TICK_LAST  = C_TW'(TICK_DIV - 1);
    localparam logic [C_DW-1:0] C_DELAY_LAST = C_DW'(HI_DELAY - 1);
    localparam logic [13:0] C_MAX        = 14'(MAX_SCORE);

    typedef enum logic [2:0] {IDLE, RUN, HOLD, COMMIT, CONV} state_t;

    state_t          state_q,     state_d;
    logic [C_TW-1:0] tick_q,      tick_d;
    logic [C_DW-1:0] delay_q,     delay_d;
    logic [13:0]     score_q,     score_d;
    logic [13:0]     score_hi_q,  score_hi_d;
    logic [15:0]     hi_bcd_q,    hi_bcd_d;
    logic            bcd_valid_q, bcd_valid_d;
    logic            new_hi_q,    new_hi_d;
    logic            running_q,   running_d;
    logic [13:0]     shift_q,     shift_d;
    logic [15:0]     digits_q,    digits_d;
    logic [3:0]      step_q,      step_d;
    logic [15:0]     w_adj;

    function automatic logic [15:0] add3(input logic [15:0] d);
        logic [15:0] r;
        r = d;
        for (int i = 0; i < 4; i++) begin
            if (r[i*4 +: 4] >= 4'd5) r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
        end
        return r;
    endfunction

    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        delay_d     = delay_q;
        score_d     = score_q;
        score_hi_d  = score_hi_q;
        hi_bcd_d    = hi_bcd_q;
        bcd_valid_d = bcd_valid_q;
        new_hi_d    = new_hi_q;
        shift_d     = shift_q;
        digits_d    = digits_q;
        step_d      = step_q;
        w_adj       = add3(digits_q);

        case (state_q)
            IDLE: begin
                if (bus.game_start) begin
                    state_d  = RUN;
                    score_d  = '0;
                    new_hi_d = 1'b0;
                    tick_d   = '0;
                end
            end
            RUN: begin
                // A hit outranks both a restart and a tick wrap in the same cycle.
                if (bus.hit) begin
                    state_d = HOLD;
                    delay_d = '0;
                end else if (bus.game_start) begin
                    score_d = '0;
                    tick_d  = '0;
                end else if (tick_q == C_TICK_LAST) begin
                    tick_d = '0;
                    if (score_q < C_MAX) score_d = score_q + 14'd1;
                end else begin
                    tick_d = tick_q + 1'b1;
                end
            end
            HOLD: begin
                if (delay_q == C_DELAY_LAST) state_d = COMMIT;
                else                         delay_d = delay_q + 1'b1;
            end
            COMMIT: begin
                if (score_q > score_hi_q) begin
                    score_hi_d = score_q;
                    new_hi_d   = 1'b1;
                end
                bcd_valid_d = 1'b0;
                step_d      = 4'd0;
                state_d     = CONV;
            end
            CONV: begin
                if (step_q == 4'd0) begin
                    shift_d  = score_hi_q;
                    digits_d = '0;
                    step_d   = 4'd1;
                end else begin
                    {digits_d, shift_d} = {w_adj, shift_q} << 1;
                    step_d = step_q + 4'd1;
                    if (step_q == 4'd14) begin
                        hi_bcd_d    = {w_adj[14:0], shift_q[13]};
                        bcd_valid_d = 1'b1;
                        state_d     = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        running_d = (state_d == RUN);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            tick_q      <= '0;
            delay_q     <= '0;
            score_q     <= '0;
            score_hi_q  <= '0;
            hi_bcd_q    <= '0;
            bcd_valid_q <= 1'b1;
            new_hi_q    <= 1'b0;
            running_q   <= 1'b0;
            shift_q     <= '0;
            digits_q    <= '0;
            step_q      <= '0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            delay_q     <= delay_d;
            score_q     <= score_d;
            score_hi_q  <= score_hi_d;
            hi_bcd_q    <= hi_bcd_d;
            bcd_valid_q <= bcd_valid_d;
            new_hi_q    <= new_hi_d;
            running_q   <= running_d;
            shift_q     <= shift_d;
            digits_q    <= digits_d;
            step_q      <= step_d;
        end
    end

    assign bus.score     = {18'd0, score_q};
    assign bus.score_hi  = {18'd0, score_hi_q};
    assign bus.hi_bcd    = hi_bcd_q;
    assign bus.bcd_valid = bcd_valid_q;
    assign bus.new_hi    = new_hi_q;
    assign bus.running   = running_q;
endmodule
`default_nettype wire

// File: tb/tb_score_keeper.sv
`default_nettype none
// ============================================================================
// Module  : tb_score_keeper
// Brief   : Directed self-checking bench for score_keeper (two parameter sets).
// Revision: 1.0 - initial release
// ============================================================================
module tb_score_keeper;
    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    score_keeper_if a_if ();
    score_keeper_if b_if ();

    score_keeper #(.TICK_DIV(4), .HI_DELAY(10), .MAX_SCORE(9999)) u_dut_a (
        .clk   (clk),
        .reset (reset),
        .bus   (a_if.slave)
    );

    score_keeper #(.TICK_DIV(2), .HI_DELAY(10), .MAX_SCORE(9999)) u_dut_b (
        .clk   (clk),
        .reset (reset),
        .bus   (b_if.slave)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic pulse_a_start();
        a_if.game_start = 1'b1; cyc(1); a_if.game_start = 1'b0;
    endtask

    task automatic pulse_a_hit();
        a_if.hit = 1'b1; cyc(1); a_if.hit = 1'b0;
    endtask

    initial begin
        a_if.game_start = 1'b0; a_if.hit = 1'b0;
        b_if.game_start = 1'b0; b_if.hit = 1'b0;
        cyc(3);
        reset = 1'b0;

        // 1: idle after reset, hit ignored
        cyc(20);
        chk("rst_score",    a_if.score,     32'd0);
        chk("rst_hi",       a_if.score_hi,  32'd0);
        chk("rst_bcd",      a_if.hi_bcd,    32'h0000);
        chk("rst_valid",    a_if.bcd_valid, 32'd1);
        chk("rst_running",  a_if.running,   32'd0);
        chk("rst_new_hi",   a_if.new_hi,    32'd0);
        pulse_a_hit(); cyc(2);
        chk("idle_hit_running", a_if.running,   32'd0);
        chk("idle_hit_valid",   a_if.bcd_valid, 32'd1);
        chk("idle_hit_hi",      a_if.score_hi,  32'd0);

        // 2: 40 cycles -> 10, hit on a wrap cycle gives no increment
        pulse_a_start();
        chk("start_running", a_if.running, 32'd1);
        chk("start_score0",  a_if.score,   32'd0);
        cyc(3);
        chk("pre_first_tick", a_if.score, 32'd0);
        cyc(1);
        chk("first_tick",     a_if.score, 32'd1);
        cyc(36);
        chk("score_10",   a_if.score,   32'd10);
        chk("running_10", a_if.running, 32'd1);
        cyc(3);
        pulse_a_hit();
        chk("hit_on_wrap_score", a_if.score,   32'd10);
        chk("hit_stops_run",     a_if.running, 32'd0);
        cyc(30);
        chk("hi_10",     a_if.score_hi,  32'd10);
        chk("bcd_10",    a_if.hi_bcd,    32'h0010);
        chk("valid_10",  a_if.bcd_valid, 32'd1);
        reset = 1'b1; cyc(1); reset = 1'b0; cyc(1);
        chk("reset_hi_clear", a_if.score_hi, 32'd0);

        // 3: run to 37, delayed commit, 15-cycle conversion
        pulse_a_start();
        cyc(148);
        chk("score_37", a_if.score, 32'd37);
        pulse_a_hit();
        chk("frozen_37", a_if.score, 32'd37);
        cyc(10);
        chk("hi_held_0",    a_if.score_hi,  32'd0);
        chk("valid_before", a_if.bcd_valid, 32'd1);
        cyc(1);
        chk("hi_37",        a_if.score_hi,  32'd37);
        chk("new_hi_set",   a_if.new_hi,    32'd1);
        chk("valid_low",    a_if.bcd_valid, 32'd0);
        cyc(14);
        chk("valid_low_14", a_if.bcd_valid, 32'd0);
        chk("bcd_held_old", a_if.hi_bcd,    32'h0000);
        cyc(1);
        chk("valid_back",   a_if.bcd_valid, 32'd1);
        chk("bcd_37",       a_if.hi_bcd,    32'h0037);

        // 4: lower score keeps high score; start during CONV ignored
        pulse_a_start();
        chk("new_hi_cleared", a_if.new_hi, 32'd0);
        cyc(80);
        chk("score_20", a_if.score, 32'd20);
        pulse_a_hit();
        cyc(11);
        chk("hi_kept_37",  a_if.score_hi,  32'd37);
        chk("new_hi_0",    a_if.new_hi,    32'd0);
        chk("valid_low_2", a_if.bcd_valid, 32'd0);
        pulse_a_start();
        chk("conv_start_ignored", a_if.running, 32'd0);
        cyc(14);
        chk("valid_back_2", a_if.bcd_valid, 32'd1);
        chk("bcd_37_again", a_if.hi_bcd,    32'h0037);
        chk("score_kept_20", a_if.score,    32'd20);

        // 5: saturation with TICK_DIV=2
        b_if.game_start = 1'b1; cyc(1); b_if.game_start = 1'b0;
        cyc(19997);
        chk("b_score_9998", b_if.score, 32'd9998);
        cyc(5003);
        chk("b_score_sat", b_if.score, 32'd9999);
        b_if.hit = 1'b1; cyc(1); b_if.hit = 1'b0;
        cyc(26);
        chk("b_hi_9999",   b_if.score_hi,  32'd9999);
        chk("b_bcd_9999",  b_if.hi_bcd,    32'h9999);
        chk("b_valid",     b_if.bcd_valid, 32'd1);
        chk("b_new_hi",    b_if.new_hi,    32'd1);

        // 6: reset mid-HOLD loses commit; start in HOLD ignored
        pulse_a_start();
        cyc(200);
        chk("score_50", a_if.score, 32'd50);
        pulse_a_hit();
        cyc(1);
        pulse_a_start();
        chk("hold_start_ignored", a_if.running, 32'd0);
        chk("hold_score_50",      a_if.score,   32'd50);
        cyc(2);
        reset = 1'b1; cyc(1);
        chk("mid_rst_score",   a_if.score,     32'd0);
        chk("mid_rst_hi",      a_if.score_hi,  32'd0);
        chk("mid_rst_bcd",     a_if.hi_bcd,    32'h0000);
        chk("mid_rst_valid",   a_if.bcd_valid, 32'd1);
        chk("mid_rst_new_hi",  a_if.new_hi,    32'd0);
        chk("mid_rst_running", a_if.running,   32'd0);
        reset = 1'b0;
        cyc(30);
        chk("commit_lost_hi",  a_if.score_hi,  32'd0);
        chk("commit_lost_bcd", a_if.hi_bcd,    32'h0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
